// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART register bridge.
//   state_t : bridge FSM states
//   CMD_WR / CMD_RD : command opcodes carried in the first byte of a frame
//   ACK / NAK       : response bytes returned to the host
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    ST_CMD_RD,
    ST_CMD_LAT,
    ST_ADDR_RD,
    ST_ADDR_LAT,
    ST_DATA_RD,
    ST_DATA_LAT,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_WR = 8'hA5;
  localparam logic [7:0] CMD_RD = 8'h5A;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

endpackage

// File: rtl/uart_bridge_regfile.sv
// NREG x DBIT register file for the UART register bridge.
//   clk   : clock, writes on rising edge
//   rst   : asynchronous active-high clear of every register
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : combinational read address
//   rdata : combinational read data
//   reg0  : continuous copy of register 0
module uart_bridge_regfile
  import uart_bridge_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DBIT-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DBIT-1:0] rdata,
  output logic [DBIT-1:0] reg0
);

  logic [DBIT-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
  assign reg0  = mem[0];

endmodule

// File: rtl/uart_reg_bridge.sv
// UART-to-register bridge. Parses host frames from a UART receive FIFO
// (write: A5 ADDR DATA, read: 5A ADDR) and answers each frame with a
// single byte (ACK, register contents or NAK) through the transmit FIFO.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   rx_empty : receive FIFO empty flag
//   r_data   : receive FIFO data, valid the cycle after rd_uart
//   rd_uart  : receive FIFO pop strobe
//   tx_full  : transmit FIFO full flag
//   wr_uart  : transmit FIFO push strobe
//   w_data   : transmit FIFO write data
//   reg0_out : continuous copy of register 0
//   err_cnt  : saturating count of NAKs and inter-byte timeouts
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int NREG    = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] reg0_out,
  output logic [7:0]      err_cnt
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          state, state_nxt;
  logic [DBIT-1:0] resp, resp_nxt;
  logic            resp_ld;
  logic            cmd_wr;
  logic            cmd_wr_ld;
  logic [AW-1:0]   addr;
  logic            addr_ld;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_clr;
  logic            tmo_inc;
  logic            tmo_hit;
  logic            err_inc;
  logic            reg_we;
  logic            rd_c;
  logic            wr_c;
  logic            addr_ok;
  logic [AW-1:0]   addr_in;
  logic [DBIT-1:0] reg_rdata;

  assign addr_in = r_data[AW-1:0];
  assign addr_ok = (int'(r_data) < NREG);
  assign tmo_hit = (tmo_cnt >= TW'(TIMEOUT - 1));

  uart_bridge_regfile #(
    .DBIT (DBIT),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (reg_we),
    .waddr (addr),
    .wdata (r_data),
    .raddr (addr_in),
    .rdata (reg_rdata),
    .reg0  (reg0_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CMD_RD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    resp_ld   = 1'b0;
    resp_nxt  = resp;
    cmd_wr_ld = 1'b0;
    addr_ld   = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    err_inc   = 1'b0;
    reg_we    = 1'b0;
    case (state)
      ST_CMD_RD: begin
        if (!rx_empty) begin
          rd_c      = 1'b1;
          state_nxt = ST_CMD_LAT;
        end
      end
      ST_CMD_LAT: begin
        if (r_data == CMD_WR || r_data == CMD_RD) begin
          cmd_wr_ld = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = ST_ADDR_RD;
        end else begin
          resp_ld   = 1'b1;
          resp_nxt  = NAK;
          err_inc   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_ADDR_RD: begin
        // A waiting byte always wins over a timeout in the same cycle.
        if (!rx_empty) begin
          rd_c      = 1'b1;
          state_nxt = ST_ADDR_LAT;
        end else if (tmo_hit) begin
          err_inc   = 1'b1;
          state_nxt = ST_CMD_RD;
        end else begin
          tmo_inc   = 1'b1;
        end
      end
      ST_ADDR_LAT: begin
        if (!addr_ok) begin
          resp_ld   = 1'b1;
          resp_nxt  = NAK;
          err_inc   = 1'b1;
          state_nxt = ST_RESP;
        end else if (cmd_wr) begin
          addr_ld   = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = ST_DATA_RD;
        end else begin
          resp_ld   = 1'b1;
          resp_nxt  = reg_rdata;
          state_nxt = ST_RESP;
        end
      end
      ST_DATA_RD: begin
        if (!rx_empty) begin
          rd_c      = 1'b1;
          state_nxt = ST_DATA_LAT;
        end else if (tmo_hit) begin
          err_inc   = 1'b1;
          state_nxt = ST_CMD_RD;
        end else begin
          tmo_inc   = 1'b1;
        end
      end
      ST_DATA_LAT: begin
        reg_we    = 1'b1;
        resp_ld   = 1'b1;
        resp_nxt  = ACK;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (!tx_full) begin
          wr_c      = 1'b1;
          state_nxt = ST_CMD_RD;
        end
      end
      default: state_nxt = ST_CMD_RD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp    <= '0;
      cmd_wr  <= 1'b0;
      addr    <= '0;
      tmo_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (resp_ld)   resp   <= resp_nxt;
      if (cmd_wr_ld) cmd_wr <= (r_data == CMD_WR);
      if (addr_ld)   addr   <= addr_in;
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
      if (err_inc)   err_cnt <= sat_inc8(err_cnt);
    end
  end

  // Strobes are forced low while reset is asserted.
  assign rd_uart = rd_c & ~rst;
  assign wr_uart = wr_c & ~rst;
  assign w_data  = resp;

endmodule

// File: tb/tb_uart_reg_bridge.sv
module tb_uart_reg_bridge;

  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [7:0] reg0_out;
  logic [7:0] err_cnt;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  int checks = 0;
  int errors = 0;
  int n_tx   = 0;
  int n_exp  = 0;
  int e0;

  uart_reg_bridge #(
    .DBIT    (8),
    .NREG    (8),
    .TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .reg0_out (reg0_out),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Receive FIFO model: pop on rd_uart, data visible the next cycle.
  always @(posedge clk) begin
    if (rd_uart && rxq.size() > 0) r_data <= rxq.pop_front();
  end

  always begin
    @(posedge clk);
    #2;
    rx_empty = (rxq.size() == 0);
  end

  // Transmit side scoreboard.
  always @(negedge clk) begin
    if (rd_uart && wr_uart) chk("rd_wr_excl", 32'(rd_uart & wr_uart), 32'd0);
    if (wr_uart) begin
      n_tx++;
      if (expq.size() > 0) chk("w_data", 32'(w_data), 32'(expq.pop_front()));
      else                 chk("extra_wr", n_tx, n_exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic expect_tx(input logic [7:0] b);
    expq.push_back(b);
    n_exp++;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (expq.size() > 0 && k < 5000) begin
      tick(1);
      k++;
    end
    chk(tag, expq.size(), 0);
    expq.delete();
    tick(2);
  endtask

  task automatic measure(input string tag, input int exp_lat);
    int k;
    int lat;
    k = 0;
    @(negedge clk);
    while (!rd_uart && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_rd"}, 32'(rd_uart), 32'd1);
    lat = 0;
    while (!wr_uart && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, lat, exp_lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(1);
    push_rx(8'h5A);
    tick(2);
    chk("rst_rd_uart", 32'(rd_uart), 0);
    chk("rst_wr_uart", 32'(wr_uart), 0);
    chk("rst_w_data", 32'(w_data), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_reg0", 32'(reg0_out), 0);
    rxq.delete();
    tick(1);
    rst = 1'b0;
    tick(2);

    // Basic write, read-back, bad address, bad command
    push_rx(8'hA5); push_rx(8'h03); push_rx(8'h3C); expect_tx(8'h06);
    drain("wr3_drain");
    chk("wr3_one_resp", n_tx, n_exp);
    push_rx(8'h5A); push_rx(8'h03); expect_tx(8'h3C);
    drain("rd3_drain");
    push_rx(8'h5A); push_rx(8'h09); expect_tx(8'h15);
    drain("badaddr_drain");
    chk("badaddr_err", 32'(err_cnt), 1);
    push_rx(8'h77); expect_tx(8'h15);
    drain("badcmd_drain");
    chk("badcmd_err", 32'(err_cnt), 2);
    push_rx(8'h5A); push_rx(8'h00); expect_tx(8'h00);
    drain("rd0_drain");

    // Minimum latency
    push_rx(8'h5A); push_rx(8'h01); expect_tx(8'h00);
    measure("lat_rd", 4);
    drain("lat_rd_drain");
    push_rx(8'hA5); push_rx(8'h05); push_rx(8'h99); expect_tx(8'h06);
    measure("lat_wr", 6);
    drain("lat_wr_drain");
    push_rx(8'h5A); push_rx(8'h05); expect_tx(8'h99);
    drain("rd5_drain");

    // Inter-byte timeout
    e0 = int'(err_cnt);
    push_rx(8'hA5);
    tick(TMO + 5);
    chk("tmo_err", 32'(err_cnt), e0 + 1);
    chk("tmo_no_resp", n_tx, n_exp);
    push_rx(8'h5A); push_rx(8'h03); expect_tx(8'h3C);
    drain("post_tmo_drain");

    // Slow but in-time bytes must not time out
    e0 = int'(err_cnt);
    push_rx(8'hA5);
    tick(TMO - 20);
    push_rx(8'h04); push_rx(8'h5C); expect_tx(8'h06);
    drain("slow_wr_drain");
    chk("slow_wr_err", 32'(err_cnt), e0);
    push_rx(8'h5A); push_rx(8'h04); expect_tx(8'h5C);
    drain("rd4_drain");

    // Back-pressure from the transmit FIFO
    tx_full = 1'b1;
    push_rx(8'h5A); push_rx(8'h03); expect_tx(8'h3C);
    tick(8);
    push_rx(8'h5A); push_rx(8'h04); expect_tx(8'h5C);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_rd", 32'(rd_uart), 0);
      chk("hold_wr", 32'(wr_uart), 0);
    end
    @(posedge clk);
    #1;
    tx_full = 1'b0;
    @(negedge clk);
    chk("push_on_fall", 32'(wr_uart), 1);
    tick(1);
    drain("txfull_drain");

    // Reset clears registers; mid-frame reset drops the frame
    push_rx(8'hA5); push_rx(8'h00); push_rx(8'h55); expect_tx(8'h06);
    drain("wr0_drain");
    chk("reg0_55", 32'(reg0_out), 32'h55);
    rst = 1'b1;
    tick(1);
    chk("rst2_reg0", 32'(reg0_out), 0);
    chk("rst2_err", 32'(err_cnt), 0);
    chk("rst2_w_data", 32'(w_data), 0);
    rst = 1'b0;
    tick(2);
    push_rx(8'hA5); push_rx(8'h00);
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(20);
    chk("midframe_no_resp", n_tx, n_exp);
    chk("midframe_reg0", 32'(reg0_out), 0);
    push_rx(8'h3C); expect_tx(8'h15);
    drain("stray_drain");
    chk("stray_err", 32'(err_cnt), 1);
    push_rx(8'hA5); push_rx(8'h00); push_rx(8'hAA); expect_tx(8'h06);
    drain("wr0aa_drain");
    chk("reg0_aa", 32'(reg0_out), 32'hAA);

    // Error counter saturation
    for (int i = 0; i < 256; i++) begin
      push_rx(8'h77);
      expect_tx(8'h15);
    end
    drain("sat_drain");
    chk("err_sat", 32'(err_cnt), 255);
    chk("total_resp", n_tx, n_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
